// File: rtl/spawn_scheduler.sv
// spawn_scheduler
// ---------------
// Paces alien spawns into event_core while the game is in the in-game scene.
// On every level start it latches a spawn interval (in 0.1 s ticks) and a
// spawn quota derived from the level number. It then raises one spawn request
// per interval, stalls while the object table is full, and holds each request
// until event_core acknowledges it.
//
// Ports
//   clk           in   system clock (100 MHz)
//   rst           in   synchronous active-high reset
//   level_start   in   one-cycle pulse on entry to the in-game scene; (re)arms
//   en            in   high while the in-game scene is active
//   cur_level     in   level number, sampled only on level_start
//   object_count  in   live objects reported by event_core
//   spawn_ack     in   one-cycle pulse: event_core latched the spawn
//   spawn_req     out  spawn request, held until acknowledged
//   spawns_done   out  quota for this level fully issued
//   spawn_index   out  spawns acknowledged so far this level
//   sched_state   out  FSM state (IDLE=0, WAIT=1, REQ=2, DONE=3)

module spawn_scheduler #(
  parameter int unsigned TICK_CYCLES = 10_000_000,
  parameter int unsigned OBJ_LIMIT   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       level_start,
  input  logic       en,
  input  logic [3:0] cur_level,
  input  logic [3:0] object_count,
  input  logic       spawn_ack,
  output logic       spawn_req,
  output logic       spawns_done,
  output logic [4:0] spawn_index,
  output logic [1:0] sched_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_REQ  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int unsigned   TW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  state_t        state, next_state;
  logic [TW-1:0] tick_cnt;
  logic [5:0]    interval_cnt;
  logic [5:0]    interval_q;
  logic [4:0]    quota_q;

  // Per-level parameters, computed from cur_level and latched on level_start.
  logic [5:0] four_l, two_l, quota_sum, interval_next;
  logic [4:0] quota_next;
  logic       has_room, tick, enter_wait;
  logic [4:0] index_inc;

  // NOTE: every signal assigned in an always_comb gets a default at the top
  // of the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    four_l        = {cur_level, 2'b00};
    two_l         = {1'b0, cur_level, 1'b0};
    quota_sum     = 6'd6 + two_l;
    // Compare before subtracting: 50 - 4L only evaluated when it stays >= 20.
    interval_next = (four_l > 6'd30) ? 6'd20 : (6'd50 - four_l);
    quota_next    = (two_l > 6'd24) ? 5'd30 : quota_sum[4:0];
  end

  assign has_room  = ({28'd0, object_count} < OBJ_LIMIT);
  assign tick      = (state == S_WAIT) && (tick_cnt == TICK_LAST);
  assign index_inc = spawn_index + 5'd1;

  // Next-state logic; priority is level_start, then !en, then normal flow.
  always_comb begin
    next_state = state;
    if (level_start) begin
      next_state = S_WAIT;
    end else if (!en) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: next_state = S_IDLE;
        S_WAIT: if (interval_cnt == interval_q && has_room) next_state = S_REQ;
        S_REQ:  if (spawn_ack) next_state = (index_inc == quota_q) ? S_DONE : S_WAIT;
        S_DONE: next_state = S_DONE;
        default: next_state = S_IDLE;
      endcase
    end
  end

  // Counters restart on every entry to WAIT, including a re-arm while in WAIT.
  assign enter_wait = (next_state == S_WAIT) && ((state != S_WAIT) || level_start);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values and ordering between blocks cannot matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      tick_cnt     <= '0;
      interval_cnt <= '0;
      interval_q   <= '0;
      quota_q      <= '0;
      spawn_index  <= '0;
      spawn_req    <= 1'b0;
      spawns_done  <= 1'b0;
    end else begin
      state       <= next_state;
      // Outputs registered from next_state so they line up with the state.
      spawn_req   <= (next_state == S_REQ);
      spawns_done <= (next_state == S_DONE);

      if (level_start) begin
        interval_q  <= interval_next;
        quota_q     <= quota_next;
        spawn_index <= '0;
      end else if (!en) begin
        spawn_index <= '0;
      end else if (state == S_REQ && spawn_ack) begin
        spawn_index <= index_inc;
      end

      if (enter_wait) begin
        tick_cnt     <= '0;
        interval_cnt <= '0;
      end else if (state == S_WAIT) begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        // Saturates at the interval; a full table holds it there (stall).
        if (tick && interval_cnt < interval_q) interval_cnt <= interval_cnt + 6'd1;
      end
    end
  end

  assign sched_state = state;

endmodule
